// File: rtl/csnc_xor_combiner.sv
// Streaming GF(2) combiner: XOR-accumulates N_IN coefficient-masked shifted words
// into one coded word, presented on a valid/ready output held until accepted.
module csnc_xor_combiner #(
  parameter int WIDTH = 4,
  parameter int N_IN  = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [WIDTH-1:0]                       in_data,
  input  logic                                   in_coef,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [WIDTH-1:0]                       out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0] grp_cnt
);

  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_IN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_out_data;
  logic [CW-1:0]     r_grp_cnt;

  logic [WIDTH-1:0]  w_mask;
  logic              w_in_fire;
  logic              w_last;

  assign w_mask    = in_coef ? in_data : {WIDTH{1'b0}};
  // Ready depends only on state and out_ready, never on in_valid.
  assign in_ready  = (r_state == ACCUM) | out_ready;
  assign w_in_fire = in_valid & in_ready;
  assign w_last    = (r_grp_cnt == LAST_IDX);

  assign out_data  = r_out_data;
  assign out_valid = (r_state == HOLD);
  assign grp_cnt   = r_grp_cnt;

  // Accumulation FSM with held output; HOLD accepts a new word only when the output drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ACCUM;
      r_acc      <= {WIDTH{1'b0}};
      r_out_data <= {WIDTH{1'b0}};
      r_grp_cnt  <= {CW{1'b0}};
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_in_fire) begin
            if (w_last) begin
              r_out_data <= r_acc ^ w_mask;
              r_acc      <= {WIDTH{1'b0}};
              r_grp_cnt  <= {CW{1'b0}};
              r_state    <= HOLD;
            end else begin
              r_acc      <= r_acc ^ w_mask;
              r_grp_cnt  <= r_grp_cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (in_valid) begin
              // Group counter is zero here, so w_last is only true when N_IN == 1.
              if (w_last) begin
                r_out_data <= w_mask;
                r_state    <= HOLD;
              end else begin
                r_acc      <= w_mask;
                r_grp_cnt  <= CW'(1);
                r_state    <= ACCUM;
              end
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        default: begin
          r_state   <= ACCUM;
          r_acc     <= {WIDTH{1'b0}};
          r_grp_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csnc_xor_combiner.sv
// Directed bench for csnc_xor_combiner: one N_IN=3 instance and one N_IN=1 instance.
module tb_csnc_xor_combiner;

  logic       clk;
  logic       rst_n;

  logic [3:0] a_in_data;
  logic       a_in_coef;
  logic       a_in_valid;
  logic       a_in_ready;
  logic [3:0] a_out_data;
  logic       a_out_valid;
  logic       a_out_ready;
  logic [1:0] a_grp_cnt;

  logic [3:0] b_in_data;
  logic       b_in_coef;
  logic       b_in_valid;
  logic       b_in_ready;
  logic [3:0] b_out_data;
  logic       b_out_valid;
  logic       b_out_ready;
  logic [0:0] b_grp_cnt;

  int n_cmp;
  int n_fail;

  csnc_xor_combiner #(.WIDTH(4), .N_IN(3)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_coef(a_in_coef), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .grp_cnt(a_grp_cnt)
  );

  csnc_xor_combiner #(.WIDTH(4), .N_IN(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_coef(b_in_coef), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .grp_cnt(b_grp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word on instance A and let it be sampled at the next edge.
  task automatic send_a(input logic [3:0] d, input logic c);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_coef  = c;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    a_in_data = 4'h0; a_in_coef = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_data = 4'h0; b_in_coef = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    #12;
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_grp_cnt", a_grp_cnt, 2'd0);
    chk("rst_out_data", a_out_data, 4'h0);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", a_in_ready, 1'b1);

    // Group 0x3^0x5^0x9 = 0xF
    send_a(4'h3, 1'b1);
    chk("g1_cnt1", a_grp_cnt, 2'd1);
    send_a(4'h5, 1'b1);
    chk("g1_cnt2", a_grp_cnt, 2'd2);
    chk("g1_not_valid", a_out_valid, 1'b0);
    send_a(4'h9, 1'b1);
    chk("g1_valid", a_out_valid, 1'b1);
    chk("g1_data", a_out_data, 4'hF);
    chk("g1_cnt0", a_grp_cnt, 2'd0);
    a_in_valid = 1'b0;
    tick();
    chk("g1_drained", a_out_valid, 1'b0);

    // Coefs 1,0,1 -> 0x3^0x9 = 0xA
    send_a(4'h3, 1'b1);
    send_a(4'h5, 1'b0);
    send_a(4'h9, 1'b1);
    chk("g2_valid", a_out_valid, 1'b1);
    chk("g2_data", a_out_data, 4'hA);
    a_in_valid = 1'b0;
    tick();

    // All-zero coefficients still produce an output
    send_a(4'h3, 1'b0);
    send_a(4'h5, 1'b0);
    send_a(4'h9, 1'b0);
    chk("g3_valid", a_out_valid, 1'b1);
    chk("g3_data", a_out_data, 4'h0);
    a_in_valid = 1'b0;
    tick();

    // Backpressure: 0x1^0x2^0x4 = 0x7 held for 5 cycles
    a_out_ready = 1'b0;
    send_a(4'h1, 1'b1);
    send_a(4'h2, 1'b1);
    send_a(4'h4, 1'b1);
    a_in_valid = 1'b1; a_in_data = 4'h8; a_in_coef = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", a_in_ready, 1'b0);
      chk("bp_valid", a_out_valid, 1'b1);
      chk("bp_data", a_out_data, 4'h7);
      chk("bp_cnt", a_grp_cnt, 2'd0);
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", a_in_ready, 1'b1);
    tick();
    chk("bp_drain_valid", a_out_valid, 1'b0);
    chk("bp_next_cnt", a_grp_cnt, 2'd1);
    send_a(4'h1, 1'b1);
    send_a(4'h2, 1'b1);
    chk("bp_next_data", a_out_data, 4'hB);
    chk("bp_next_valid", a_out_valid, 1'b1);

    // Back-to-back stream 1,2,4,8,8,1 -> 0x7 then 0x1
    begin
      logic [3:0] words [6];
      words = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h8, 4'h1};
      a_in_valid = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) begin
        a_in_valid = 1'b1; a_in_data = words[i]; a_in_coef = 1'b1;
        #1;
        chk("b2b_in_ready", a_in_ready, 1'b1);
        tick();
        if (i == 2) begin
          chk("b2b_out1_valid", a_out_valid, 1'b1);
          chk("b2b_out1_data", a_out_data, 4'h7);
        end
        if (i == 3) begin
          chk("b2b_mid_valid", a_out_valid, 1'b0);
          chk("b2b_mid_cnt", a_grp_cnt, 2'd1);
        end
      end
      chk("b2b_out2_valid", a_out_valid, 1'b1);
      chk("b2b_out2_data", a_out_data, 4'h1);
    end
    a_in_valid = 1'b0;
    tick();

    // Reset mid-group discards the partial accumulation
    send_a(4'h3, 1'b1);
    send_a(4'h5, 1'b1);
    a_in_valid = 1'b0;
    chk("mr_pre_cnt", a_grp_cnt, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", a_out_valid, 1'b0);
    chk("mr_cnt", a_grp_cnt, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_a(4'h6, 1'b1);
    send_a(4'h6, 1'b1);
    send_a(4'h1, 1'b1);
    chk("mr_valid_after", a_out_valid, 1'b1);
    chk("mr_data_after", a_out_data, 4'h1);
    a_in_valid = 1'b0;
    tick();

    // N_IN=1 pass-through: 0xA (coef 1) then 0x5 (coef 0)
    b_in_valid = 1'b1; b_in_data = 4'hA; b_in_coef = 1'b1;
    tick();
    chk("n1_valid0", b_out_valid, 1'b1);
    chk("n1_data0", b_out_data, 4'hA);
    chk("n1_cnt", b_grp_cnt, 1'b0);
    b_in_data = 4'h5; b_in_coef = 1'b0;
    #1;
    chk("n1_in_ready", b_in_ready, 1'b1);
    tick();
    chk("n1_valid1", b_out_valid, 1'b1);
    chk("n1_data1", b_out_data, 4'h0);
    b_in_valid = 1'b0;
    tick();
    chk("n1_drained", b_out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/csnc_xor_combiner.md
Name: csnc_xor_combiner

Overview:
- Streaming GF(2) combiner directly downstream of the static cyclic shifters.
- Accepts one cyclically shifted WIDTH-bit word per handshake, each tagged with a 1-bit GF(2) coefficient.
- XOR-accumulates N_IN words into one coded word and presents it on a valid/ready output.
- Forms the encoding core of the cyclic-shift network-coding datapath.

Parameters:
- WIDTH, 4, bit width of each shifted word and of the coded output.
- N_IN, 3, words combined per coded output. Legal values: N_IN >= 1.
- Group counter width is derived internally as max(1, $clog2(N_IN)). It is not a parameter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  shifted word from the cyclic shifter.
- in_coef  input  1  GF(2) coefficient. 1 means include in_data; 0 means contribute zero.
- in_valid  input  1  in_data/in_coef valid.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  WIDTH  coded word (XOR of included words of one group).
- out_valid  output  1  out_data valid; held until accepted.
- out_ready  input  1  downstream accepts out_data.
- grp_cnt  output  max(1,$clog2(N_IN))  words accepted so far in the current group (0..N_IN-1).

Behaviour:
- Handshakes: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready, sampled at rising clk.
- Masked word: m = in_coef ? in_data : 0.
- State: two-state FSM ACCUM / HOLD, plus acc[WIDTH-1:0], out_data register, grp_cnt.
- Reset (async, rst_n=0): state=ACCUM, acc=0, grp_cnt=0, out_data=0, out_valid=0. in_ready=1 while rst_n=1 and state=ACCUM. A partially accumulated group is discarded.
- in_ready (combinational) = (state==ACCUM) | out_ready. No combinational path from in_valid to in_ready. out_valid = (state==HOLD), registered.
- Input transfer with grp_cnt < N_IN-1: acc <= acc ^ m; grp_cnt <= grp_cnt+1.
- Input transfer with grp_cnt == N_IN-1 (last word):
  - out_data <= acc ^ m; acc <= 0; grp_cnt <= 0; state <= HOLD.
  - Latency: out_valid rises the cycle after the last word is accepted.
- HOLD with out_ready=0:
  - out_data and out_valid stable.
  - in_ready=0; no input accepted.
  - acc and grp_cnt frozen.
- HOLD with out_ready=1 and no input transfer: output completes; state <= ACCUM.
- HOLD with out_ready=1 and simultaneous input transfer:
  - Output completes and the input is accepted as word 0 of the next group (no bubble).
  - If that word is also the group's last (N_IN==1): out_data <= m and state stays HOLD.
  - Otherwise: acc <= m, grp_cnt <= 1, state <= ACCUM.
- Sustained throughput: one word per cycle when out_ready=1, i.e. one coded word per N_IN cycles.
- N_IN==1: every accepted word passes through as out_data = m with 1-cycle latency.
- Coefficient 0 on every word of a group yields out_data=0 with out_valid=1. The output is still produced.
- in_data/in_coef are ignored when no input transfer occurs.
- Arithmetic is bitwise XOR only: no carries, no width growth.

Test Plan:
- WIDTH=4, N_IN=3, out_ready=1: words 0x3,0x5,0x9, coef 1,1,1 on consecutive cycles -> out_valid=1 one cycle after the third word, out_data=0xF, grp_cnt returns to 0.
- Coefs 1,0,1 with words 0x3,0x5,0x9 -> out_data=0xA. Coefs 0,0,0 -> out_data=0x0 with out_valid=1.
- Backpressure: complete a group, then hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_data stable, grp_cnt=0. Raise out_ready -> output transfers and the next word is accepted in the same cycle.
- Back-to-back stream of 6 words (0x1,0x2,0x4,0x8,0x8,0x1), all coef=1, out_ready=1, in_valid continuous -> outputs 0x7 then 0x1, in_ready never drops.
- Reset mid-group: accept 0x3,0x5, assert rst_n=0 asynchronously -> out_valid=0, grp_cnt=0 immediately. After release, words 0x6,0x6,0x1 -> out_data=0x1.
- N_IN=1: words 0xA,0x5, coef 1,0, continuous, out_ready=1 -> outputs 0xA then 0x0, each one cycle after acceptance.
